prng_wrapper: RTL and testbench

Pseudo-random number source that emits one OUTPUT_SIZE-bit value per AXI4-Stream transfer. It uses a maximal-length Fibonacci LFSR and never emits the value EXCLUDE.

It drives stream consumers such as the `AXISReferenceComparator` checker and randomised-traffic inputs elsewhere in the design. The output sequence is fully determined by SEED, so it can be reproduced against a reference value file.

---
 rtl/prng_pkg.sv | 60 ++++++
 rtl/prng_lfsr.sv | 48 ++++
 rtl/prng_wrapper.sv | 48 ++++
 tb/tb_prng_wrapper.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// rtl/prng_pkg.sv - shared LFSR tap table and step function for the PRNG source
package prng_pkg;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 32;

  // Mask with the single bit for tap position n (1-indexed, as in tap tables).
  function automatic logic [31:0] tap_bit(input int n);
    return 32'(1) << (n - 1);
  endfunction

  // Maximal-length Fibonacci tap mask for widths 3..32.
  // Taps are listed 1-indexed, so width 8 uses bits 7,5,4,3.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] m;
    m = '0;
    case (width)
      3:  m = tap_bit(3)  | tap_bit(2);
      4:  m = tap_bit(4)  | tap_bit(3);
      5:  m = tap_bit(5)  | tap_bit(3);
      6:  m = tap_bit(6)  | tap_bit(5);
      7:  m = tap_bit(7)  | tap_bit(6);
      8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
      9:  m = tap_bit(9)  | tap_bit(5);
      10: m = tap_bit(10) | tap_bit(7);
      11: m = tap_bit(11) | tap_bit(9);
      12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
      14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
      15: m = tap_bit(15) | tap_bit(14);
      16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: m = tap_bit(17) | tap_bit(14);
      18: m = tap_bit(18) | tap_bit(11);
      19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      20: m = tap_bit(20) | tap_bit(17);
      21: m = tap_bit(21) | tap_bit(19);
      22: m = tap_bit(22) | tap_bit(21);
      23: m = tap_bit(23) | tap_bit(18);
      24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: m = tap_bit(25) | tap_bit(22);
      26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
      28: m = tap_bit(28) | tap_bit(25);
      29: m = tap_bit(29) | tap_bit(27);
      30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      31: m = tap_bit(31) | tap_bit(28);
      32: m = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
      default: m = '0;
    endcase
    return m;
  endfunction

  // One left-shifting Fibonacci step; callers truncate to their own width.
  // Bits above the active width are zero in the state and the mask, so the
  // feedback parity only sees real taps.
  function automatic logic [31:0] lfsr_step(input logic [31:0] state, input logic [31:0] taps);
    return {state[30:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/prng_lfsr.sv
// rtl/prng_lfsr.sv - LFSR register with seed load, advance enable and value exclusion
module prng_lfsr
  import prng_pkg::*;
#(
  parameter int           W       = 8,
  parameter logic [W-1:0] SEED    = W'(63),
  parameter logic [W-1:0] EXCLUDE = W'(128)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  output logic [W-1:0] state
);

  localparam logic [31:0] TAPS = lfsr_taps(W);

  function automatic logic [W-1:0] step_w(input logic [W-1:0] s);
    return W'(lfsr_step(32'(s), TAPS));
  endfunction

  // A seed equal to the excluded value must never be shown, so start one step on.
  localparam logic [W-1:0] INIT = (SEED == EXCLUDE) ? step_w(SEED) : SEED;

  if (SEED == '0) begin : g_bad_seed
    $error("prng_lfsr: SEED must be nonzero");
  end

  logic [W-1:0] one_step;
  logic [W-1:0] two_step;
  logic [W-1:0] next_state;

  // Successor with the excluded value skipped by taking a second step.
  always_comb begin
    one_step   = step_w(state);
    two_step   = step_w(one_step);
    next_state = (one_step == EXCLUDE) ? two_step : one_step;
  end

  // State register: reload the start value on reset, advance only when asked.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else if (advance) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/prng_wrapper.sv
// rtl/prng_wrapper.sv - stream source emitting one LFSR value per transfer
module prng_wrapper
  import prng_pkg::*;
#(
  parameter int                     OUTPUT_SIZE = 8,
  parameter logic [OUTPUT_SIZE-1:0] EXCLUDE     = OUTPUT_SIZE'(128),
  parameter logic [OUTPUT_SIZE-1:0] SEED        = OUTPUT_SIZE'(63)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [OUTPUT_SIZE-1:0] out_tdata,
  output logic                   out_tlast
);

  if (OUTPUT_SIZE < MIN_WIDTH || OUTPUT_SIZE > MAX_WIDTH) begin : g_bad_width
    $error("prng_wrapper: OUTPUT_SIZE must be within 3..32");
  end

  logic valid;
  logic handshake;

  assign handshake  = valid & out_tready;
  assign out_tvalid = valid;
  assign out_tlast  = 1'b0;

  // Source is never empty: valid rises on the first edge out of reset and stays.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else begin
      valid <= 1'b1;
    end
  end

  prng_lfsr #(
    .W       (OUTPUT_SIZE),
    .SEED    (SEED),
    .EXCLUDE (EXCLUDE)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (handshake),
    .state   (out_tdata)
  );

endmodule

// File: tb/tb_prng_wrapper.sv
// tb/tb_prng_wrapper.sv - randomized self-checking bench for prng_wrapper
module tb_prng_wrapper;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ready_a = 1'b0, ready_b = 1'b0, ready_c = 1'b0;
  logic valid_a, valid_b, valid_c;
  logic last_a, last_b, last_c;
  logic [7:0] data_a, data_b, data_c;

  always #5 clk = ~clk;

  prng_wrapper #(.OUTPUT_SIZE(8), .EXCLUDE(8'd128), .SEED(8'd63)) dut_a (
    .clk(clk), .reset(reset), .out_tvalid(valid_a), .out_tready(ready_a),
    .out_tdata(data_a), .out_tlast(last_a));
  prng_wrapper #(.OUTPUT_SIZE(8), .EXCLUDE(8'd255), .SEED(8'd63)) dut_b (
    .clk(clk), .reset(reset), .out_tvalid(valid_b), .out_tready(ready_b),
    .out_tdata(data_b), .out_tlast(last_b));
  prng_wrapper #(.OUTPUT_SIZE(8), .EXCLUDE(8'd127), .SEED(8'd127)) dut_c (
    .clk(clk), .reset(reset), .out_tvalid(valid_c), .out_tready(ready_c),
    .out_tdata(data_c), .out_tlast(last_c));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1 as a plain shift-and-parity on integers.
  function automatic int ref_step(input int x);
    return ((x << 1) & 255) | (((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1);
  endfunction

  // Expected stream: the full 255-value cycle from the seed, with EXCLUDE removed.
  int exp_seq [3][254];
  task automatic build_seq(input int k, input int seed, input int excl);
    int x, n;
    x = seed;
    n = 0;
    for (int i = 0; i < 255; i++) begin
      if (x != excl && n < 254) begin
        exp_seq[k][n] = x;
        n++;
      end
      x = ref_step(x);
    end
  endtask

  // Transfers observed at the edge they occur.
  int got_a[$], got_b[$], got_c[$];
  always @(posedge clk) begin
    if (!reset) begin
      if (valid_a && ready_a) got_a.push_back(int'(data_a));
      if (valid_b && ready_b) got_b.push_back(int'(data_b));
      if (valid_c && ready_c) got_c.push_back(int'(data_c));
    end
  end

  initial begin
    int seen [256];
    int distinct;
    int cnt;

    build_seq(0, 63, 128);
    build_seq(1, 63, 255);
    build_seq(2, 127, 127);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valid_a", valid_a, 0);
    check("rst_data_a", data_a, 63);
    check("rst_data_b", data_b, 63);
    check("rst_data_c", data_c, 255);
    check("rst_last_a", last_a, 0);

    // Release: valid exactly one edge later.
    reset = 1'b0;
    ready_b = 1'b1;
    ready_c = 1'b1;
    #1 check("rel_valid_pre", valid_a, 0);
    @(negedge clk);
    check("rel_valid_post", valid_a, 1);
    check("rel_valid_c", valid_c, 1);

    // Random backpressure on A; tdata must always show the next model value.
    for (int cyc = 0; cyc < 700; cyc++) begin
      check("rand_data_a", data_a, exp_seq[0][got_a.size() % 254]);
      if (!valid_a || last_a) check("rand_ctl_a", {valid_a, last_a}, 2'b10);
      ready_a = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    ready_a = 1'b0;

    check("a_count_enough", (got_a.size() >= 255), 1);
    if (got_a.size() >= 255) begin
      check("a_first0", got_a[0], 63);
      check("a_first1", got_a[1], 127);
      check("a_first2", got_a[2], 255);
      check("a_first3", got_a[3], 254);
      check("a_first4", got_a[4], 252);
      for (int i = 0; i < 256; i++) seen[i] = 0;
      distinct = 0;
      for (int i = 0; i < 254; i++) begin
        if (seen[got_a[i]] == 0) distinct++;
        seen[got_a[i]]++;
      end
      check("a_distinct", distinct, 254);
      check("a_zero_absent", seen[0], 0);
      check("a_excl_absent", seen[128], 0);
      check("a_wrap", got_a[254], 63);
    end

    check("b_count", (got_b.size() >= 600), 1);
    if (got_b.size() >= 4) begin
      check("b_first0", got_b[0], 63);
      check("b_first1", got_b[1], 127);
      check("b_first2", got_b[2], 254);
      check("b_first3", got_b[3], 252);
    end
    foreach (got_b[i]) if (got_b[i] != exp_seq[1][i % 254]) check("b_stream", got_b[i], exp_seq[1][i % 254]);
    check("c_count", (got_c.size() >= 1), 1);
    if (got_c.size() >= 1) check("c_first", got_c[0], 255);
    foreach (got_c[i]) if (got_c[i] != exp_seq[2][i % 254]) check("c_stream", got_c[i], exp_seq[2][i % 254]);

    // Backpressure after the second value.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ready_a = 1'b1;
    @(negedge clk);
    check("bp_first", data_a, 63);
    @(negedge clk);
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", data_a, 127);
      check("bp_hold_valid", valid_a, 1);
      @(negedge clk);
    end
    check("bp_hold_final", data_a, 127);
    ready_a = 1'b1;
    @(negedge clk);
    check("bp_resume", data_a, 255);

    // Mid-stream reset after 20 transfers.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got_a.delete();
    cnt = 0;
    while (got_a.size() < 20 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("mid_reach20", (got_a.size() >= 20), 1);
    check("mid_data20", data_a, exp_seq[0][got_a.size() % 254]);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_data", data_a, 63);
    reset = 1'b0;
    got_a.delete();
    cnt = 0;
    while (got_a.size() < 1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("mid_restart_seen", (got_a.size() >= 1), 1);
    if (got_a.size() >= 1) check("mid_restart_first", got_a[0], 63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
